ibex_register_file_mp: RTL



---
 rtl/ibex_register_file_mp.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_register_file_mp.sv
// rtl/ibex_register_file_mp.sv - multi-port flop register file with optional staged write, bypass and write-enable check
// Port 1 wins write collisions everywhere: array update, bypass and shadow R0.

module ibex_register_file_mp #(
    parameter bit                  RV32E             = 1'b0,
    parameter int unsigned         DataWidth         = 32,
    parameter int unsigned         NumReadPorts      = 2,
    parameter int unsigned         NumWritePorts     = 1,
    parameter bit                  WriteDelay        = 1'b1,
    parameter bit                  Bypass            = 1'b1,
    parameter bit                  DummyInstructions = 1'b0,
    parameter bit                  WrenCheck         = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal      = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              dummy_instr_id_i,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [NumWritePorts*5-1:0]        waddr_i,
    input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
    input  logic [NumWritePorts-1:0]          we_i,
    output logic                              err_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned AddrW    = RV32E ? 4 : 5;

    typedef logic [AddrW-1:0]     addr_t;
    typedef logic [DataWidth-1:0] data_t;

    addr_t [NumWritePorts-1:0]                waddr;
    data_t [NumWritePorts-1:0]                wdata;
    logic  [NumWritePorts-1:0][NumWords-1:0]  wr_dec;

    always_comb begin
        waddr  = '0;
        wdata  = '0;
        wr_dec = '0;
        for (int w = 0; w < NumWritePorts; w++) begin
            waddr[w] = waddr_i[5*w +: AddrW];
            wdata[w] = wdata_i[DataWidth*w +: DataWidth];
            for (int i = 0; i < NumWords; i++) begin
                wr_dec[w][i] = we_i[w] && (waddr[w] == addr_t'(i));
            end
        end
    end

    // Commit source: either the live request or the one-cycle staged copy of it.
    addr_t [NumWritePorts-1:0]                cm_addr;
    data_t [NumWritePorts-1:0]                cm_data;
    logic  [NumWritePorts-1:0]                cm_we;
    logic                                     cm_dummy;
    logic  [NumWritePorts-1:0][NumWords-1:0]  cm_dec;

    if (WriteDelay) begin : g_stage
        addr_t [NumWritePorts-1:0] st_addr_q;
        data_t [NumWritePorts-1:0] st_data_q;
        logic  [NumWritePorts-1:0] st_we_q;
        logic                      st_dummy_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                st_addr_q  <= '0;
                st_data_q  <= '0;
                st_we_q    <= '0;
                st_dummy_q <= 1'b0;
            end else begin
                st_we_q <= we_i;
                if (|we_i) begin
                    st_addr_q  <= waddr;
                    st_data_q  <= wdata;
                    st_dummy_q <= dummy_instr_id_i;
                end
            end
        end

        assign cm_addr  = st_addr_q;
        assign cm_data  = st_data_q;
        assign cm_we    = st_we_q;
        assign cm_dummy = st_dummy_q;

        always_comb begin
            cm_dec = '0;
            for (int w = 0; w < NumWritePorts; w++) begin
                for (int i = 0; i < NumWords; i++) begin
                    cm_dec[w][i] = st_we_q[w] && (st_addr_q[w] == addr_t'(i));
                end
            end
        end
    end else begin : g_no_stage
        assign cm_addr  = waddr;
        assign cm_data  = wdata;
        assign cm_we    = we_i;
        assign cm_dummy = dummy_instr_id_i;
        assign cm_dec   = wr_dec;
    end

    data_t rf_q [NumWords];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                rf_q[i] <= WordZeroVal;
            end
        end else begin
            for (int i = 1; i < NumWords; i++) begin
                for (int w = 0; w < NumWritePorts; w++) begin
                    if (cm_dec[w][i]) begin
                        rf_q[i] <= cm_data[w];
                    end
                end
            end
        end
    end

    data_t r0_rd;

    if (DummyInstructions) begin : g_dummy_r0
        data_t r0_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r0_q <= WordZeroVal;
            end else begin
                for (int w = 0; w < NumWritePorts; w++) begin
                    if (cm_dec[w][0] && cm_dummy) begin
                        r0_q <= cm_data[w];
                    end
                end
            end
        end

        assign r0_rd = dummy_instr_id_i ? r0_q : WordZeroVal;
    end else begin : g_no_dummy_r0
        assign r0_rd = WordZeroVal;
    end

    addr_t [NumReadPorts-1:0] raddr;
    data_t [NumReadPorts-1:0] rdata;

    always_comb begin
        raddr   = '0;
        rdata   = '0;
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            raddr[p] = raddr_i[5*p +: AddrW];
            rdata[p] = (raddr[p] == '0) ? r0_rd : rf_q[raddr[p]];
            if (Bypass) begin
                // Address 0 forwards only a dummy write seen while ID still holds a dummy.
                for (int w = 0; w < NumWritePorts; w++) begin
                    if (cm_we[w] && (cm_addr[w] == raddr[p]) &&
                        ((raddr[p] != '0) ||
                         (DummyInstructions && dummy_instr_id_i && cm_dummy))) begin
                        rdata[p] = cm_data[w];
                    end
                end
            end
            rdata_o[DataWidth*p +: DataWidth] = rdata[p];
        end
    end

    if (WrenCheck) begin : g_wren_check
        logic err_d;
        logic err_q;

        always_comb begin
            err_d = err_q;
            for (int w = 0; w < NumWritePorts; w++) begin
                if (wr_dec[w] != (NumWords'(we_i[w]) << waddr[w])) begin
                    err_d = 1'b1;
                end
                if (we_i[w] && !$onehot(wr_dec[w])) begin
                    err_d = 1'b1;
                end
                if (!we_i[w] && (|wr_dec[w])) begin
                    err_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err_o = err_q;
    end else begin : g_no_wren_check
        assign err_o = 1'b0;
    end

    logic unused_sink;
    assign unused_sink = ^{raddr_i, waddr_i, wr_dec, cm_dec};

endmodule
